// File: rtl/mp_arith_seq_pkg.sv
// Shared types for the byte-serial multi-precision add/subtract sequencer.
// FSM state encoding and operation encoding.
package mp_arith_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/mp_arith_seq_if.sv
// Control, operand and result streams of the multi-precision sequencer.
// master = operand/result side, slave = sequencer.
interface mp_arith_seq_if #(
  parameter int LEN_W = 4
);

  logic             start;
  logic             op_sub;
  logic [LEN_W-1:0] len;
  logic             busy;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_x;
  logic [7:0]       in_y;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_byte;
  logic             out_last;
  logic             done;
  logic             carry_out;
  logic             zero;

  modport master (
    output start, op_sub, len,
    output in_valid, in_x, in_y,
    output out_ready,
    input  busy, in_ready,
    input  out_valid, out_byte, out_last,
    input  done, carry_out, zero
  );

  modport slave (
    input  start, op_sub, len,
    input  in_valid, in_x, in_y,
    input  out_ready,
    output busy, in_ready,
    output out_valid, out_byte, out_last,
    output done, carry_out, zero
  );

endinterface

// File: rtl/mp_arith_seq_addsub.sv
// Shared 8-bit add/subtract ALU slice.
// sub forces cin=1 and inverts y; carry=0 ignores cin.
module mp_arith_seq_addsub (
  input  logic       sub,
  input  logic       carry,
  input  logic       cin,
  input  logic [7:0] x,
  input  logic [7:0] y,
  output logic [7:0] sum,
  output logic       cout
);

  logic [7:0] w_y;
  logic       w_c;
  logic [8:0] w_r;

  assign w_y = sub ? ~y : y;
  assign w_c = sub ? 1'b1 : (carry & cin);
  assign w_r = {1'b0, x} + {1'b0, w_y} + {8'b0, w_c};
  assign {cout, sum} = w_r;

endmodule

// File: rtl/mp_arith_seq.sv
// Byte-serial multi-precision add/subtract sequencer.
// Chains carry/borrow LSB-first through the shared 8-bit ALU slice.
module mp_arith_seq
  import mp_arith_seq_pkg::*;
#(
  parameter int LEN_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  mp_arith_seq_if.slave     bus
);

  localparam logic [LEN_W:0] CNT_ONE  = (LEN_W+1)'(1);
  localparam logic [LEN_W:0] CNT_FULL = {1'b1, {LEN_W{1'b0}}};

  state_t         r_state;
  logic [LEN_W:0] r_cnt;
  logic           r_op;
  logic           r_c;
  logic           r_zacc;
  logic           r_busy;
  logic           r_ovalid;
  logic           r_olast;
  logic [7:0]     r_obyte;
  logic           r_done;
  logic           r_cout;
  logic           r_zero;

  logic           w_in_ready;
  logic           w_in_hs;
  logic           w_out_hs;
  logic [7:0]     w_y;
  logic [7:0]     w_sum;
  logic           w_cout;
  logic [LEN_W:0] w_len;

  assign w_in_ready = (r_state == ST_RUN) &&
                      (!r_ovalid || bus.out_ready);
  assign w_in_hs    = w_in_ready && bus.in_valid;
  assign w_out_hs   = r_ovalid && bus.out_ready;
  assign w_y        = (r_op == OP_SUB) ? ~bus.in_y : bus.in_y;
  assign w_len      = (bus.len == '0) ? CNT_FULL
                                      : {1'b0, bus.len};

  // Subtract is x + ~y + c with c seeded to 1, so the slice's own
  // sub input (which forces cin=1 every byte) stays unused.
  mp_arith_seq_addsub u_addsub (
    .sub   (1'b0),
    .carry (1'b1),
    .cin   (r_c),
    .x     (bus.in_x),
    .y     (w_y),
    .sum   (w_sum),
    .cout  (w_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_op     <= OP_ADD;
      r_c      <= 1'b0;
      r_zacc   <= 1'b0;
      r_busy   <= 1'b0;
      r_ovalid <= 1'b0;
      r_olast  <= 1'b0;
      r_obyte  <= 8'h00;
      r_done   <= 1'b0;
      r_cout   <= 1'b0;
      r_zero   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_op    <= bus.op_sub;
            r_cnt   <= w_len;
            r_c     <= bus.op_sub;
            r_zacc  <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_in_hs) begin
            r_obyte  <= w_sum;
            r_ovalid <= 1'b1;
            r_c      <= w_cout;
            r_zacc   <= r_zacc & (w_sum == 8'h00);
            r_cnt    <= r_cnt - CNT_ONE;
            if (r_cnt == CNT_ONE) begin
              r_olast <= 1'b1;
              r_state <= ST_DRAIN;
            end
          end else if (w_out_hs) begin
            r_ovalid <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (w_out_hs) begin
            r_ovalid <= 1'b0;
            r_olast  <= 1'b0;
            r_cout   <= r_c;
            r_zero   <= r_zacc;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_ovalid;
  assign bus.out_byte  = r_obyte;
  assign bus.out_last  = r_olast;
  assign bus.done      = r_done;
  assign bus.carry_out = r_cout;
  assign bus.zero      = r_zero;

endmodule

// File: doc/mp_arith_seq.md
# mp_arith_seq

Byte-serial multi-precision add/subtract sequencer. It streams operand byte pairs LSB-first through the shared 8-bit `addsub` datapath and chains the carry/borrow between bytes. It emits result bytes on a valid/ready stream and reports the final carry and a zero flag. It sits between the operand-fetch logic and the result writeback, so the 8-bit ALU can serve operations of 1..2^LEN_W bytes.

## Interface
- `LEN_W`, default 4: width of the length field; the operation length is 1..2^LEN_W bytes.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin an operation; sampled only when `busy`=0.
- `op_sub`  in  1  0 = add, 1 = subtract (x − y); latched on start.
- `len`  in  LEN_W  byte count; 0 encodes 2^LEN_W; latched on start.
- `busy`  out  1  high from the cycle after an accepted start until `done`.
- `in_valid` / `in_ready`  in/out  1  operand byte-pair handshake.
- `in_x`, `in_y`  in  8  operand bytes, LSB-first.
- `out_valid` / `out_ready`  out/in  1  result byte handshake.
- `out_byte`  out  8  result byte.
- `out_last`  out  1  qualifies the final result byte.
- `done`  out  1  one-cycle pulse at operation end.
- `carry_out`  out  1  final carry (sub: 1 = no borrow); held until the next start.
- `zero`  out  1  all result bytes were 0x00; held until the next start.

## Operation
- The FSM has three states: IDLE, RUN, DRAIN.
- **IDLE**
  - `start`=1 latches `op_sub` and `len` into `cnt`.
  - Carry register `c` <= `op_sub`; zero accumulator <= 1.
  - Transitions to RUN.
- **Datapath use**
  - `addsub` is always driven with `sub`=0, `carry`=1, `cin`=`c`, `x`=`in_x`.
  - `y` = `op_sub` ? ~`in_y` : `in_y`.
  - Subtract is implemented as x + ~y + c, with the first-byte `c`=1. The datapath's own `sub` input forces cin=1 and cannot chain a borrow, so it is never used.
- **RUN**
  - `in_ready` = !`out_valid` | `out_ready`; there is a single output register.
  - On an input handshake:
    - `out_byte` <= sum, `out_valid` <= 1.
    - `c` <= cout.
    - zero accumulator &= (sum==0).
    - `cnt` decrements.
  - When the accepted byte is the last one (`cnt`==1, or the 2^LEN_W wrap): `out_last` <= 1 and go to DRAIN.
- **DRAIN**
  - `in_ready`=0.
  - On the output handshake with `out_last`=1:
    - `out_valid` and `out_last` <= 0.
    - `carry_out` <= `c`; `zero` <= accumulator.
    - `done` pulses; `busy` drops; go to IDLE.
- **Boundary rules**
  - `start` while `busy`=1 is ignored.
  - Input presented in IDLE is not accepted (`in_ready`=0).
  - Simultaneous output handshake and input handshake in RUN: the output register reloads in the same cycle, with no bubble.
  - `len`=0 runs 2^LEN_W bytes. The count register is LEN_W+1 bits, or the wrap is handled explicitly.
  - Reset mid-operation discards all state; no `done` is produced.

## Timing
- Reset values: `busy`, `in_ready`, `out_valid`, `out_last`, `done`, `carry_out`, `zero` = 0; `out_byte`=0x00.
- Start to ready: start in cycle T gives `busy`=1 and `in_ready`=1 in T+1.
- Input handshake in cycle T gives `out_valid` in T+1, so latency is 1 cycle.
- Throughput is 1 byte/cycle when `out_ready` is held high.
- Final output handshake in T gives `done`=1, `busy`=0 and updated `carry_out`/`zero` visible in T+1.
- A new `start` is accepted in the `done` cycle.
- Minimum operation time for N bytes with no backpressure is N+2 cycles from start to done.
- Backpressure: while `out_valid`=1 and `out_ready`=0, `out_byte` and `out_last` are held stable and `in_ready`=0.

## Structure
- Shared package holds:
  - the state enum (ST_IDLE, ST_RUN, ST_DRAIN);
  - the op encoding (OP_ADD=1'b0, OP_SUB=1'b1).
- One sub-module instance: `addsub`, used as-is with `sub` tied 0 and `carry` tied 1.
- All other logic is local: FSM, counter, carry register, output register, zero accumulator.

## Test plan
- **Add with carry chain:** add, len=2, x=0x12FF, y=0x0001 → bytes 0x00, 0x13 (`out_last` on the second); `carry_out`=0, `zero`=0.
- **Subtract with borrow chain:** sub, len=2, x=0x0100, y=0x0001 → bytes 0xFF, 0x00; `carry_out`=1, `zero`=0. Also sub, len=1, 0x00−0x01 → 0xFF, `carry_out`=0.
- **Zero result:** sub, len=1, 0x05−0x05 → 0x00, `carry_out`=1, `zero`=1.
- **Backpressure:** add, len=4, `out_ready` low for 3 cycles after the second byte → `in_ready`=0 and `out_byte` stable throughout; all 4 bytes correct; `done` exactly once.
- **Full-length wrap:** len=0 (LEN_W=4), add with x=0xFF for all 16 bytes, y=0x01 then fifteen 0x00 → sixteen 0x00 bytes; `carry_out`=1, `zero`=1; `out_last` only on byte 16.
- **Start while busy and reset mid-operation:** `start` pulsed while busy → ignored. `rst_n` asserted after byte 2 of 4 → all outputs at reset values, no `done`; a new operation afterwards completes correctly.
